// File: rtl/rf_scoreboard.sv
// Parametrised register file with configurable read ports, same-cycle write bypass
// and a per-register pending-write scoreboard used by decode for hazard stalls.
module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int LOG_EN   = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic [31:0]              WrPC,
    input  logic                     IssEn,
    input  logic [ADDR_W-1:0]        IssAddr,
    output logic                     IssReady
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];

    logic wr_ok;
    logic iss_dec_hit;
    logic iss_acc;

    // Writes to $0 are dropped entirely when register 0 is hardwired.
    assign wr_ok = WrEn && !((ZERO_REG != 0) && (WrAddr == '0));

    always_comb begin
        iss_dec_hit = WrEn && (WrAddr == IssAddr) && (cnt_q[IssAddr] != '0);
        IssReady    = (cnt_q[IssAddr] != CNT_MAX) || iss_dec_hit ||
                      ((ZERO_REG != 0) && (IssAddr == '0));
    end

    assign iss_acc = IssEn && IssReady;

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            logic inc, dec;
            inc      = iss_acc && (IssAddr == ADDR_W'(r));
            dec      = WrEn && (WrAddr == ADDR_W'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec)
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            else if (dec && !inc)
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            if ((ZERO_REG != 0) && (r == 0))
                cnt_d[r] = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            if (wr_ok)
                regs_q[WrAddr] <= WrData;
            for (int r = 0; r < DEPTH; r++)
                cnt_q[r] <= cnt_d[r];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [CNT_W-1:0]  rc;
        assign ra = RdAddr[k*ADDR_W +: ADDR_W];
        assign rc = cnt_q[ra];

        always_comb begin
            RdData[k*DATA_W +: DATA_W] = regs_q[ra];
            if ((BYPASS != 0) && wr_ok && (WrAddr == ra))
                RdData[k*DATA_W +: DATA_W] = WrData;
            if ((ZERO_REG != 0) && (ra == '0))
                RdData[k*DATA_W +: DATA_W] = '0;
        end

        // Last pending write is landing now and being forwarded, so no stall needed.
        always_comb begin
            RdBusy[k] = (rc != '0);
            if ((BYPASS != 0) && WrEn && (WrAddr == ra) && (rc == CNT_ONE) &&
                !(iss_acc && (IssAddr == ra)))
                RdBusy[k] = 1'b0;
            if ((ZERO_REG != 0) && (ra == '0))
                RdBusy[k] = 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge Clk) begin
        if ((LOG_EN != 0) && !Reset && wr_ok)
            $display("@%08h: $%2d <= %08h", WrPC, WrAddr, WrData);
    end
`endif

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised general-purpose register file for the pipelined MIPS core. It replaces the fixed 32×32, two-read-port register file. It adds a configurable read-port count, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. Decode uses the scoreboard for hazard stalls: the issue port marks a destination register pending, and the writeback port clears it.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports (≥1)
- CNT_W, 2, width of each pending-write counter; max in flight per register = 2^CNT_W−1
- BYPASS, 1, 1 = a read of the register being written returns WrData in the same cycle
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues
- LOG_EN, 1, 1 = print a simulation log line on every committed write
- Clk  input  1  single clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high
- RdAddr  input  NUM_RD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W]
- RdData  output  NUM_RD*DATA_W  read data, combinational
- RdBusy  output  NUM_RD  1 = port k's register has an uncleared pending write
- WrEn  input  1  write/commit strobe from writeback
- WrAddr  input  ADDR_W  write address
- WrData  input  DATA_W  write data
- WrPC  input  32  PC of the committing instruction; used only for the log
- IssEn  input  1  issue strobe: the instruction with destination IssAddr has entered the pipe
- IssAddr  input  ADDR_W  destination being issued
- IssReady  output  1  1 = an issue to IssAddr is accepted this cycle

## Operation
- Storage: 2^ADDR_W × DATA_W array `regs`, plus 2^ADDR_W × CNT_W counters `cnt`.
- Reset (Reset=1 at a clock edge): every regs entry = 0 and every cnt entry = 0. Reset overrides WrEn and IssEn in the same cycle, and no log line is printed.
- Write: on an edge with WrEn=1, regs[WrAddr] ← WrData. When ZERO_REG=1, a write with WrAddr=0 is dropped (no update, no log).
- Logging (LOG_EN=1): each committed write prints `@<WrPC hex 8>: $<WrAddr decimal 2> <= <WrData hex 8>`.
- Read: RdData[k] = regs[RdAddr[k]]. Overrides:
  - ZERO_REG=1 and RdAddr[k]=0 → 0.
  - BYPASS=1, WrEn=1, WrAddr=RdAddr[k], write not dropped → WrData.
- Counter update per register r, each edge:
  - inc = IssEn & IssReady & IssAddr==r
  - dec = WrEn & WrAddr==r & cnt[r]≠0
  - inc & dec → unchanged; inc only → +1; dec only → −1.
  - When ZERO_REG=1, r=0 never changes.
- No underflow: a write to a register with cnt=0 updates data only.
- IssReady = cnt[IssAddr] ≠ max, or a dec hits IssAddr this cycle, or (ZERO_REG=1 and IssAddr=0).
  - An issue with IssReady=0 is ignored. The upstream stage must hold the instruction.
- RdBusy[k] = cnt[RdAddr[k]] ≠ 0, except:
  - 0 when the counter will reach 0 at this edge due to dec and BYPASS=1 (the data is being forwarded now).
  - 0 for register 0 when ZERO_REG=1.

## Timing
- Write latency: 1 edge to the array. With BYPASS=1, a read sees the new value the same cycle (0-cycle). With BYPASS=0, the read sees it the cycle after the edge.
- Issue latency: RdBusy rises the cycle after the accepted-issue edge; it does not assert in the issue cycle.
- RdData, RdBusy and IssReady are purely combinational from inputs and state. No output register.
- After reset: RdData = 0 on all ports, RdBusy = 0, IssReady = 1.
- Multiple read ports addressing the same register return identical data and busy.
- Reset asserted mid-sequence: pending counts are discarded. The next cycle behaves as after power-up.

## Test plan
- Reset, then write $5←0x12345678 (PC 0x3000) → one log line `@00003000: $ 5 <= 12345678`; RdAddr0=5 reads 0x12345678 in the write cycle (BYPASS=1) and after.
- Write $0←0xFFFFFFFF → no log line; register 0 reads 0 on all ports; IssEn with IssAddr=0 leaves RdBusy for $0 at 0.
- Issue $8 three times (CNT_W=2) → RdBusy=1 from the next cycle; IssReady=0 for $8 after the third issue; a fourth IssEn is ignored. Three writes return cnt to 0 and drop RdBusy in the third write cycle.
- Same-cycle IssEn $9 and WrEn $9 with cnt[9]=1 → cnt stays 1; RdBusy stays 1; RdData = WrData.
- Write $3 with cnt[3]=0 → data updates and cnt stays 0 (no wrap to 3).
- Reset asserted together with WrEn $4←0xAA and IssEn $4 → after the edge, $4 reads 0, RdBusy=0, and no log line is printed.
